// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// the FSM state encoding and the default operand width.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_addsub_n.sv
// Parameterized N-bit adder/subtractor shared by the arithmetic lab.
// control=0 adds, control=1 subtracts as a + ~b + 1; co is the carry out,
// so in subtract mode co=1 means no borrow (a >= b, unsigned).
module addsub_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         control,
    output logic [N-1:0] r,
    output logic         co
);

    logic [N:0] sum;

    // Invert b and inject the carry-in when subtracting.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b ^ {N{control}}} + {{N{1'b0}}, control};
        r   = sum[N-1:0];
        co  = sum[N];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one trial subtraction per clock,
// WIDTH iterations per operation, start/done handshake, divide-by-zero flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_r;
    logic             trial_co;
    logic             trial_ok;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // The shifted partial remainder keeps its carried-out MSB (WIDTH+1 bits),
    // otherwise large divisors would lose a bit and give wrong quotients.
    always_comb begin
        trial_a  = {r_reg, q_reg[WIDTH-1]};
        trial_b  = {1'b0, d_reg};
        trial_ok = trial_co & ~trial_r[WIDTH];
        q_next   = {q_reg[WIDTH-2:0], trial_ok};
        r_next   = trial_ok ? trial_r[WIDTH-1:0] : trial_a[WIDTH-1:0];
    end

    addsub_n #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a       (trial_a),
        .b       (trial_b),
        .control (1'b1),
        .r       (trial_r),
        .co      (trial_co)
    );

    // Control FSM plus datapath registers; every output is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            count       <= '0;
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        d_reg       <= divisor;
                        q_reg       <= dividend;
                        r_reg       <= '0;
                        count       <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= FIN;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state     <= FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 4).
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int pass_count  = 0;
    int check_count = 0;
    int lat;

    seq_divider #(
        .WIDTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock; edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start at the current negedge and wait (bounded) for done.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, output int cycles);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        cycles   = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end while (done !== 1'b1 && cycles < 20);
    endtask

    // Directed sequence followed by an exhaustive operand sweep.
    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_quot", 32'(quotient), 32'd0);
        checkOutput("rst_rem", 32'(remainder), 32'd0);
        checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] 13/4 single start");
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("t1_busy_c%0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("t1_done_c%0d", i), 32'(done), 32'd0);
        end
        @(negedge clk);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_busy_fin", 32'(busy), 32'd0);
        checkOutput("t1_quot", 32'(quotient), 32'd3);
        checkOutput("t1_rem", 32'(remainder), 32'd1);
        checkOutput("t1_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        checkOutput("t1_done_drop", 32'(done), 32'd0);

        $display("[TB] 15/1 then 3/5 with start held");
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                dividend = 4'd3;
                divisor  = 4'd5;
            end
        end
        checkOutput("t2a_done", 32'(done), 32'd1);
        checkOutput("t2a_quot", 32'(quotient), 32'd15);
        checkOutput("t2a_rem", 32'(remainder), 32'd0);
        @(negedge clk);
        checkOutput("t2_gap_busy", 32'(busy), 32'd0);
        checkOutput("t2_gap_done", 32'(done), 32'd0);
        checkOutput("t2_gap_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        checkOutput("t2b_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        start = 1'b0;
        checkOutput("t2b_done", 32'(done), 32'd1);
        checkOutput("t2b_quot", 32'(quotient), 32'd0);
        checkOutput("t2b_rem", 32'(remainder), 32'd3);
        @(negedge clk);

        $display("[TB] 9/0 divide by zero");
        start = 1'b1; dividend = 4'd9; divisor = 4'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        checkOutput("t3_quot", 32'(quotient), 32'hF);
        checkOutput("t3_rem", 32'(remainder), 32'd9);
        checkOutput("t3_dbz", 32'(div_by_zero), 32'd1);
        @(negedge clk);
        checkOutput("t3_done_drop", 32'(done), 32'd0);
        checkOutput("t3_busy_idle", 32'(busy), 32'd0);

        $display("[TB] 14/3 with ignored restart");
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_quot", 32'(quotient), 32'd4);
        checkOutput("t4_rem", 32'(remainder), 32'd2);
        checkOutput("t4_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        checkOutput("t4_busy_after", 32'(busy), 32'd0);
        checkOutput("t4_done_after", 32'(done), 32'd0);

        $display("[TB] reset in the middle of 12/5");
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_quot", 32'(quotient), 32'd0);
        checkOutput("t5_rem", 32'(remainder), 32'd0);
        checkOutput("t5_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(4'd12, 4'd5, lat);
        checkOutput("t5_lat", 32'(lat), 32'd5);
        checkOutput("t5_quot2", 32'(quotient), 32'd2);
        checkOutput("t5_rem2", 32'(remainder), 32'd2);
        @(negedge clk);

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(4'(a), 4'(b), lat);
                checkOutput($sformatf("sw_done_%0d_%0d", a, b), 32'(done), 32'd1);
                if (b == 0) begin
                    checkOutput($sformatf("sw_lat_%0d_%0d", a, b), 32'(lat), 32'd1);
                    checkOutput($sformatf("sw_quot_%0d_%0d", a, b), 32'(quotient), 32'hF);
                    checkOutput($sformatf("sw_rem_%0d_%0d", a, b), 32'(remainder), 32'(a));
                    checkOutput($sformatf("sw_dbz_%0d_%0d", a, b), 32'(div_by_zero), 32'd1);
                end else begin
                    checkOutput($sformatf("sw_lat_%0d_%0d", a, b), 32'(lat), 32'd5);
                    checkOutput($sformatf("sw_quot_%0d_%0d", a, b), 32'(quotient), 32'(a / b));
                    checkOutput($sformatf("sw_rem_%0d_%0d", a, b), 32'(remainder), 32'(a % b));
                    checkOutput($sformatf("sw_inv_%0d_%0d", a, b),
                                32'(32'(quotient) * 32'(b) + 32'(remainder)), 32'(a));
                    checkOutput($sformatf("sw_dbz_%0d_%0d", a, b), 32'(div_by_zero), 32'd0);
                end
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
